// File: rtl/cond_code_unit.sv
// Y86-64 condition-code register and jXX/cmovXX condition evaluator.
// Captures ZF/SF/OF from the ALU on OPq and evaluates cnd from the stored flags.
module cond_code_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_cc,
  input  logic             cc_hold,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_overflow,
  input  logic [3:0]       ifun,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             cnd,
  output logic             cnd_err,
  output logic [15:0]      cc_updates
);

  typedef enum logic {
    CC_IDLE    = 1'b0,
    CC_CAPTURE = 1'b1
  } cc_phase_e;

  typedef enum logic [3:0] {
    C_ALWAYS = 4'd0,
    C_LE     = 4'd1,
    C_L      = 4'd2,
    C_E      = 4'd3,
    C_NE     = 4'd4,
    C_GE     = 4'd5,
    C_G      = 4'd6
  } cond_e;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } flags_t;

  localparam flags_t FLAGS_RST = '{zf: 1'b1, sf: 1'b0, of: 1'b0};
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  cc_phase_e phase;
  flags_t    flags_q;
  flags_t    flags_n;
  logic      lt;

  // Candidate flags straight from the ALU; only become visible after the edge.
  always_comb begin
    flags_n.zf = (alu_out == '0);
    flags_n.sf = alu_out[WIDTH-1];
    flags_n.of = alu_overflow;
  end

  // Single-cycle classification: hold dominates set_cc, reset dominates both.
  always_comb begin
    phase = CC_IDLE;
    if (set_cc && !cc_hold && !rst) begin
      phase = CC_CAPTURE;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q    <= FLAGS_RST;
      cc_updates <= '0;
    end else if (phase == CC_CAPTURE) begin
      flags_q <= flags_n;
      if (cc_updates != CNT_MAX) begin
        cc_updates <= cc_updates + 16'd1;
      end
    end
  end

  assign zf = flags_q.zf;
  assign sf = flags_q.sf;
  assign of = flags_q.of;
  assign lt = flags_q.sf ^ flags_q.of;

  // NOTE: outputs get defaults before the case so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cnd     = 1'b0;
    cnd_err = 1'b0;
    case (cond_e'(ifun))
      C_ALWAYS: cnd = 1'b1;
      C_LE:     cnd = lt | flags_q.zf;
      C_L:      cnd = lt;
      C_E:      cnd = flags_q.zf;
      C_NE:     cnd = ~flags_q.zf;
      C_GE:     cnd = ~lt;
      C_G:      cnd = ~lt & ~flags_q.zf;
      default:  cnd_err = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_cond_code_unit.sv
// Directed self-checking bench for cond_code_unit with hand-computed expectations.
module tb_cond_code_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        set_cc;
  logic        cc_hold;
  logic [63:0] alu_out;
  logic        alu_overflow;
  logic [3:0]  ifun;
  logic        zf, sf, of, cnd, cnd_err;
  logic [15:0] cc_updates;

  int n_vec = 0;
  int n_err = 0;

  cond_code_unit #(.WIDTH(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .set_cc       (set_cc),
    .cc_hold      (cc_hold),
    .alu_out      (alu_out),
    .alu_overflow (alu_overflow),
    .ifun         (ifun),
    .zf           (zf),
    .sf           (sf),
    .of           (of),
    .cnd          (cnd),
    .cnd_err      (cnd_err),
    .cc_updates   (cc_updates)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic ez, input logic es, input logic eo);
    check({tag, ".zf"}, 64'(zf), 64'(ez));
    check({tag, ".sf"}, 64'(sf), 64'(es));
    check({tag, ".of"}, 64'(of), 64'(eo));
  endtask

  task automatic check_cnd(input string tag, input logic [3:0] f, input logic ec, input logic ee);
    ifun = f;
    #1;
    check({tag, ".cnd"}, 64'(cnd), 64'(ec));
    check({tag, ".cnd_err"}, 64'(cnd_err), 64'(ee));
  endtask

  logic [6:0] reset_cnd_tbl;

  initial begin
    rst          = 1'b1;
    set_cc       = 1'b0;
    cc_hold      = 1'b0;
    alu_out      = '0;
    alu_overflow = 1'b0;
    ifun         = 4'd0;
    // Bit i is the expected cnd for ifun=i with Z=1,S=0,O=0.
    reset_cnd_tbl = 7'b0101011;

    tick();
    rst = 1'b0;
    check_flags("reset", 1'b1, 1'b0, 1'b0);
    check("reset.cc_updates", 64'(cc_updates), 64'd0);
    for (int i = 0; i < 7; i++) begin
      check_cnd($sformatf("reset.ifun%0d", i), 4'(i), reset_cnd_tbl[i], 1'b0);
    end

    // 0x7FFF..F + 1: negative with overflow; cnd must not see it before the edge.
    set_cc       = 1'b1;
    alu_out      = 64'h8000_0000_0000_0000;
    alu_overflow = 1'b1;
    check_cnd("same_cycle.e", 4'd3, 1'b1, 1'b0);
    tick();
    set_cc = 1'b0;
    check_flags("ovf", 1'b0, 1'b1, 1'b1);
    check("ovf.cc_updates", 64'(cc_updates), 64'd1);
    check_cnd("ovf.l", 4'd2, 1'b0, 1'b0);
    check_cnd("ovf.g", 4'd6, 1'b1, 1'b0);

    // 69 - 420 = -351
    set_cc       = 1'b1;
    alu_out      = -64'sd351;
    alu_overflow = 1'b0;
    tick();
    set_cc = 1'b0;
    check_flags("neg", 1'b0, 1'b1, 1'b0);
    check("neg.cc_updates", 64'(cc_updates), 64'd2);
    check_cnd("neg.le", 4'd1, 1'b1, 1'b0);
    check_cnd("neg.ge", 4'd5, 1'b0, 1'b0);
    check_cnd("neg.ne", 4'd4, 1'b1, 1'b0);

    // Zero result, then a hold-blocked capture of 5.
    set_cc  = 1'b1;
    alu_out = '0;
    tick();
    check_flags("zero", 1'b1, 1'b0, 1'b0);
    check("zero.cc_updates", 64'(cc_updates), 64'd3);
    cc_hold = 1'b1;
    alu_out = 64'd5;
    tick();
    set_cc  = 1'b0;
    cc_hold = 1'b0;
    check_flags("hold", 1'b1, 1'b0, 1'b0);
    check("hold.cc_updates", 64'(cc_updates), 64'd3);
    check_cnd("hold.e", 4'd3, 1'b1, 1'b0);

    // Undefined condition codes.
    check_cnd("bad7", 4'd7, 1'b0, 1'b1);
    check_cnd("bad15", 4'd15, 1'b0, 1'b1);

    // Saturation: 3 + 65532 reaches exactly 0xFFFF, then 8 more must not wrap.
    set_cc  = 1'b1;
    alu_out = 64'd1;
    repeat (65532) @(posedge clk);
    #1;
    check("sat.reach", 64'(cc_updates), 64'hFFFF);
    repeat (8) @(posedge clk);
    #1;
    check("sat.hold", 64'(cc_updates), 64'hFFFF);
    check_flags("sat", 1'b0, 1'b0, 1'b0);

    // Reset wins over a simultaneous capture.
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    set_cc = 1'b0;
    check("rst_mid.cc_updates", 64'(cc_updates), 64'd0);
    check_flags("rst_mid", 1'b1, 1'b0, 1'b0);
    check_cnd("rst_mid.always", 4'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
